// File: rtl/protobuf_pkg.sv
// Shared wire-type codes, error codes and FSM state encoding for the protobuf deserializer.
package protobuf_pkg;

    localparam logic [2:0] WT_VARINT  = 3'd0;
    localparam logic [2:0] WT_FIXED64 = 3'd1;
    localparam logic [2:0] WT_LEN     = 3'd2;
    localparam logic [2:0] WT_SGROUP  = 3'd3;
    localparam logic [2:0] WT_EGROUP  = 3'd4;
    localparam logic [2:0] WT_FIXED32 = 3'd5;

    localparam logic [2:0] E_NONE        = 3'd0;
    localparam logic [2:0] E_TAG_LONG    = 3'd1;
    localparam logic [2:0] E_FIELD_ZERO  = 3'd2;
    localparam logic [2:0] E_FIELD_RANGE = 3'd3;
    localparam logic [2:0] E_WTYPE       = 3'd4;
    localparam logic [2:0] E_LEN         = 3'd5;
    localparam logic [2:0] E_TRUNC       = 3'd6;
    localparam logic [2:0] E_VARINT_LONG = 3'd7;

    typedef enum logic [2:0] {
        S_TAG,
        S_VARINT,
        S_FIXED,
        S_LEN,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    function automatic logic wtype_ok(input logic [2:0] wt, input logic fixed64_en);
        return (wt == WT_VARINT) || (wt == WT_LEN) || (wt == WT_FIXED32) ||
               (fixed64_en && (wt == WT_FIXED64));
    endfunction

endpackage

// File: rtl/pb_varint_accum.sv
// Little-endian base-128 varint accumulator; value/ovf outputs already include the byte being stepped.
module pb_varint_accum (
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        clear,
    input  logic        step,
    input  logic [7:0]  byte_in,
    output logic [31:0] value,
    output logic [3:0]  idx,
    output logic        done,
    output logic        too_long,
    output logic        ovf
);
    logic [31:0] value_q;
    logic [3:0]  idx_q;
    logic        ovf_q;
    logic [70:0] shifted;

    // 71 bits so that every payload bit of byte 9 still lands somewhere visible to ovf
    assign shifted  = {64'd0, byte_in[6:0]} << (7 * idx_q);
    assign value    = value_q | shifted[31:0];
    assign ovf      = ovf_q | (|shifted[70:32]);
    assign done     = step & ~byte_in[7];
    assign too_long = step & byte_in[7] & (idx_q == 4'd9);
    assign idx      = idx_q;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            value_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clear || done) begin
            value_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (step) begin
            value_q <= value;
            ovf_q   <= ovf;
            idx_q   <= idx_q + 4'd1;
        end
    end

endmodule

// File: rtl/protobuf_deserializer.sv
// Protobuf byte-stream decoder emitting field beats; define PROTOBUF_DESER_FIXED64_EN to decode wire type 1.
//  state     | meaning
//  S_TAG     | collecting tag varint bytes
//  S_VARINT  | collecting varint value bytes
//  S_FIXED   | collecting fixed32/fixed64 bytes
//  S_LEN     | collecting length varint of a len-delimited field
//  S_PAYLOAD | packing len-delimited payload bytes into beats
//  S_DRAIN   | discarding bytes after an error until in_last
module protobuf_deserializer
    import protobuf_pkg::*;
#(
    parameter int FIELD_W = 16,
    parameter int MAX_LEN = 1023
) (
    input  logic               clock_clk,
    input  logic               reset_reset_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] out_field,
    output logic [2:0]         out_wtype,
    output logic [31:0]        out_data,
    output logic [3:0]         out_strb,
    output logic               out_first,
    output logic               out_last,
    output logic               out_ovf,
    output logic               err_valid,
    output logic [2:0]         err_code,
    output logic               busy
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;

    state_t             state;
    logic [FIELD_W-1:0] cur_field;
    logic [2:0]         cur_wtype;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W-1:0]   fixed_bytes;
    logic [1:0]         lane;
    logic [31:0]        pack;
    logic [31:0]        pack_nxt;
    logic [3:0]         strb_nxt;
    logic               first_pend;
    logic               accept, beat_end, last_byte;
    logic               tag_long, tag_range, wtype_bad, len_bad;
    logic               err_now;
    logic [2:0]         err_sel;

    logic        acc_step;
    logic [31:0] acc_value;
    logic [3:0]  acc_idx;
    logic        acc_done, acc_too_long, acc_ovf;

`ifdef PROTOBUF_DESER_FIXED64_EN
    localparam logic FIXED64_EN = 1'b1;
    assign fixed_bytes = (acc_value[2:0] == WT_FIXED64) ? CNT_W'(8) : CNT_W'(4);
`else
    localparam logic FIXED64_EN = 1'b0;
    assign fixed_bytes = CNT_W'(4);
`endif

    assign in_ready  = (state == S_DRAIN) | ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign busy      = (state != S_TAG) || (acc_idx != 4'd0);
    assign acc_step  = accept && ((state == S_TAG) || (state == S_VARINT) || (state == S_LEN));

    assign tag_long  = ((acc_idx == 4'd4) && in_data[7]) || acc_ovf;
    assign tag_range = (acc_value >> (FIELD_W + 3)) != 32'd0;
    assign wtype_bad = !wtype_ok(acc_value[2:0], FIXED64_EN);
    assign len_bad   = acc_ovf || (acc_value > 32'(MAX_LEN));

    assign last_byte = (rem == CNT_W'(1));
    assign beat_end  = (lane == 2'd3) || last_byte;
    assign pack_nxt  = pack | ({24'd0, in_data} << {lane, 3'b000});

    always_comb begin
        case (lane)
            2'd0:    strb_nxt = 4'b0001;
            2'd1:    strb_nxt = 4'b0011;
            2'd2:    strb_nxt = 4'b0111;
            default: strb_nxt = 4'b1111;
        endcase
    end

    pb_varint_accum u_accum (
        .clk_sys  (clock_clk),
        .rst_b    (reset_reset_n),
        .clear    (err_now),
        .step     (acc_step),
        .byte_in  (in_data),
        .value    (acc_value),
        .idx      (acc_idx),
        .done     (acc_done),
        .too_long (acc_too_long),
        .ovf      (acc_ovf)
    );

    // Specific decode errors take priority over truncation on the same byte
    always_comb begin
        err_now = 1'b0;
        err_sel = E_NONE;
        if (accept) begin
            case (state)
                S_TAG: begin
                    if (tag_long)                                     err_sel = E_TAG_LONG;
                    else if (acc_done && (acc_value[31:3] == 29'd0))  err_sel = E_FIELD_ZERO;
                    else if (acc_done && tag_range)                   err_sel = E_FIELD_RANGE;
                    else if (acc_done && wtype_bad)                   err_sel = E_WTYPE;
                    else if (in_last)                                 err_sel = E_TRUNC;
                end
                S_VARINT: begin
                    if (acc_too_long)                 err_sel = E_VARINT_LONG;
                    else if (in_last && !acc_done)    err_sel = E_TRUNC;
                end
                S_LEN: begin
                    if (acc_too_long)                 err_sel = E_VARINT_LONG;
                    else if (acc_done && len_bad)     err_sel = E_LEN;
                    else if (in_last && !(acc_done && (acc_value == 32'd0))) err_sel = E_TRUNC;
                end
                S_FIXED, S_PAYLOAD: begin
                    if (in_last && !last_byte)        err_sel = E_TRUNC;
                end
                default: err_sel = E_NONE;
            endcase
            err_now = (err_sel != E_NONE);
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= S_TAG;
            cur_field  <= '0;
            cur_wtype  <= '0;
            rem        <= '0;
            lane       <= '0;
            pack       <= '0;
            first_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_field  <= '0;
            out_wtype  <= '0;
            out_data   <= '0;
            out_strb   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_ovf    <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= E_NONE;
        end else begin
            err_valid <= err_now;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (err_now) begin
                err_code <= err_sel;
                state    <= in_last ? S_TAG : S_DRAIN;
                pack     <= '0;
                lane     <= '0;
            end else if (accept) begin
                case (state)
                    S_TAG: if (acc_done) begin
                        cur_field  <= acc_value[FIELD_W+2:3];
                        cur_wtype  <= acc_value[2:0];
                        first_pend <= 1'b1;
                        pack       <= '0;
                        lane       <= '0;
                        if (acc_value[2:0] == WT_VARINT)
                            state <= S_VARINT;
                        else if (acc_value[2:0] == WT_LEN)
                            state <= S_LEN;
                        else begin
                            rem   <= fixed_bytes;
                            state <= S_FIXED;
                        end
                    end
                    S_VARINT: if (acc_done) begin
                        out_valid <= 1'b1;
                        out_field <= cur_field;
                        out_wtype <= cur_wtype;
                        out_data  <= acc_value;
                        out_strb  <= 4'hF;
                        out_first <= 1'b1;
                        out_last  <= 1'b1;
                        out_ovf   <= acc_ovf;
                        state     <= S_TAG;
                    end
                    S_LEN: if (acc_done) begin
                        if (acc_value == 32'd0) begin
                            out_valid <= 1'b1;
                            out_field <= cur_field;
                            out_wtype <= cur_wtype;
                            out_data  <= '0;
                            out_strb  <= 4'h0;
                            out_first <= 1'b1;
                            out_last  <= 1'b1;
                            out_ovf   <= 1'b0;
                            state     <= S_TAG;
                        end else begin
                            rem   <= acc_value[CNT_W-1:0];
                            state <= S_PAYLOAD;
                        end
                    end
                    S_FIXED, S_PAYLOAD: begin
                        rem <= rem - CNT_W'(1);
                        if (beat_end) begin
                            out_valid  <= 1'b1;
                            out_field  <= cur_field;
                            out_wtype  <= cur_wtype;
                            out_data   <= pack_nxt;
                            out_strb   <= strb_nxt;
                            out_first  <= first_pend;
                            out_last   <= last_byte;
                            out_ovf    <= 1'b0;
                            first_pend <= 1'b0;
                            pack       <= '0;
                            lane       <= '0;
                            if (last_byte)
                                state <= S_TAG;
                        end else begin
                            pack <= pack_nxt;
                            lane <= lane + 2'd1;
                        end
                    end
                    S_DRAIN: if (in_last) state <= S_TAG;
                    default: state <= S_TAG;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_protobuf_deserializer.sv
// Scoreboard bench for protobuf_deserializer; expected beats/errors queued as bytes are driven.
module tb_protobuf_deserializer;
    import protobuf_pkg::*;

    typedef struct packed {
        logic [15:0] field;
        logic [2:0]  wtype;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        first;
        logic        last;
        logic        ovf;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic        out_valid, out_ready;
    logic [15:0] out_field;
    logic [2:0]  out_wtype;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_first, out_last, out_ovf;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;
    beat_t exp_q[$];
    logic [2:0] err_q[$];
    beat_t mon_exp, mon_got;
    logic [2:0] mon_err;

    always #5 clk = ~clk;

    protobuf_deserializer #(.FIELD_W(16), .MAX_LEN(1023)) dut (
        .clock_clk     (clk),
        .reset_reset_n (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_field     (out_field),
        .out_wtype     (out_wtype),
        .out_data      (out_data),
        .out_strb      (out_strb),
        .out_first     (out_first),
        .out_last      (out_last),
        .out_ovf       (out_ovf),
        .err_valid     (err_valid),
        .err_code      (err_code),
        .busy          (busy)
    );

    function automatic beat_t mk(input logic [15:0] f, input logic [2:0] w, input logic [31:0] d,
                                 input logic [3:0] s, input logic fi, input logic la, input logic ov);
        beat_t b;
        b = {f, w, d, s, fi, la, ov};
        return b;
    endfunction

    // Output and error monitor: each handshaken beat / error pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_total++;
            mon_got = {out_field, out_wtype, out_data, out_strb, out_first, out_last, out_ovf};
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected got=%h required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL beat got=%h required=%h", mon_got, mon_exp);
                else
                    n_pass++;
            end
        end
        if (rst_n && err_valid) begin
            n_total++;
            if (err_q.size() == 0) begin
                $display("FAIL err_unexpected got=%0d required=none", err_code);
            end else begin
                mon_err = err_q.pop_front();
                if (err_code !== mon_err)
                    $display("FAIL err_code got=%0d required=%0d", err_code, mon_err);
                else
                    n_pass++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard;
        guard = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_total++;
            $display("FAIL in_ready_timeout byte=%h got=0 required=1", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b required=0", out_valid); else n_pass++;
        n_total++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid got=%b required=0", err_valid); else n_pass++;
        n_total++; if (err_code !== 3'd0) $display("FAIL reset_err_code got=%0d required=0", err_code); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", busy); else n_pass++;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_varint;
        exp_q.push_back(mk(16'd1, WT_VARINT, 32'h96, 4'hF, 1'b1, 1'b1, 1'b0));
        send_byte(8'h08, 1'b0);
        n_total++; if (busy !== 1'b1) $display("FAIL busy_mid_field got=%b required=1", busy); else n_pass++;
        send_byte(8'h96, 1'b0);
        send_byte(8'h01, 1'b1);
        n_total++; if (out_valid !== 1'b1) $display("FAIL beat_latency got=%b required=1", out_valid); else n_pass++;
        idle(3);
        n_total++; if (busy !== 1'b0) $display("FAIL busy_idle got=%b required=0", busy); else n_pass++;
    endtask

    task automatic test_len_delim;
        logic [7:0] msg [7];
        msg = '{8'h12, 8'h05, 8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        exp_q.push_back(mk(16'd2, WT_LEN, 32'h6C6C6568, 4'hF, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(16'd2, WT_LEN, 32'h0000006F, 4'h1, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 7; i++) send_byte(msg[i], i == 6);
        idle(3);
    endtask

    task automatic test_empty_and_fixed32;
        logic [7:0] msg [7];
        msg = '{8'h1A, 8'h00, 8'h0D, 8'h78, 8'h56, 8'h34, 8'h12};
        exp_q.push_back(mk(16'd3, WT_LEN, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(16'd1, WT_FIXED32, 32'h12345678, 4'hF, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 7; i++) send_byte(msg[i], i == 6);
        idle(3);
    endtask

    task automatic test_wtype;
        err_q.push_back(E_WTYPE);
        send_byte(8'h0B, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        exp_q.push_back(mk(16'd1, WT_VARINT, 32'h1, 4'hF, 1'b1, 1'b1, 1'b0));
        send_byte(8'h08, 1'b0);
        send_byte(8'h01, 1'b1);
        idle(3);
        n_total++; if (err_code !== E_WTYPE) $display("FAIL err_code_hold got=%0d required=%0d", err_code, E_WTYPE); else n_pass++;
`ifdef PROTOBUF_DESER_FIXED64_EN
        exp_q.push_back(mk(16'd1, WT_FIXED64, 32'h04030201, 4'hF, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(16'd1, WT_FIXED64, 32'h08070605, 4'hF, 1'b0, 1'b1, 1'b0));
`else
        err_q.push_back(E_WTYPE);
`endif
        send_byte(8'h09, 1'b0);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        idle(3);
    endtask

    task automatic test_errors;
        err_q.push_back(E_TRUNC);
        send_byte(8'h08, 1'b1);
        err_q.push_back(E_VARINT_LONG);
        send_byte(8'h08, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b1);
        exp_q.push_back(mk(16'd1, WT_VARINT, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 1'b1));
        send_byte(8'h08, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'h1F, 1'b1);
        err_q.push_back(E_FIELD_RANGE);
        send_byte(8'h80, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h20, 1'b1);
        err_q.push_back(E_FIELD_ZERO);
        send_byte(8'h00, 1'b1);
        exp_q.push_back(mk(16'hFFFF, WT_VARINT, 32'h5, 4'hF, 1'b1, 1'b1, 1'b0));
        send_byte(8'hF8, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h1F, 1'b0);
        send_byte(8'h05, 1'b1);
        err_q.push_back(E_LEN);
        send_byte(8'h12, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b1);
        idle(3);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        exp_q.push_back(mk(16'd2, WT_LEN, 32'h13121110, 4'hF, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(16'd2, WT_LEN, 32'h17161514, 4'hF, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(16'd2, WT_LEN, 32'h1B1A1918, 4'hF, 1'b0, 1'b1, 1'b0));
        fork
            begin
                send_byte(8'h12, 1'b0);
                send_byte(8'h0C, 1'b0);
                for (int i = 0; i < 12; i++) send_byte(8'h10 + 8'(i), i == 11);
            end
            begin
                idle(15);
                n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b required=0", in_ready); else n_pass++;
                n_total++; if (out_valid !== 1'b1 || out_data !== 32'h13121110)
                    $display("FAIL stall_hold got=%b/%h required=1/13121110", out_valid, out_data);
                else n_pass++;
                idle(5);
                out_ready = 1'b1;
            end
        join
        idle(3);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send_byte(8'h12, 1'b0);
        send_byte(8'h08, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL pre_reset_valid got=%b required=1", out_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_mid_valid got=%b required=0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_mid_busy got=%b required=0", busy); else n_pass++;
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        exp_q.push_back(mk(16'd1, WT_VARINT, 32'h2A, 4'hF, 1'b1, 1'b1, 1'b0));
        send_byte(8'h08, 1'b0);
        send_byte(8'h2A, 1'b1);
        idle(3);
    endtask

    task automatic test_drain_queues;
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1;
        n_total++; if (exp_q.size() != 0) $display("FAIL beats_missing got=%0d required=0", exp_q.size()); else n_pass++;
        n_total++; if (err_q.size() != 0) $display("FAIL errs_missing got=%0d required=0", err_q.size()); else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(2);
        test_reset;
        test_varint;
        test_len_delim;
        test_empty_and_fixed32;
        test_wtype;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_drain_queues;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
